// File: rtl/edge_implication_monitor.sv
// edge_implication_monitor
//   Multi-channel run-time checker for "a |-> ##[0:WINDOW] <edge>(b)".
//   Each channel samples a[i]/b[i] on posedge clk and resolves one attempt
//   at a time. It reports pass/fail pulses, saturating counters and a
//   sticky error flag.
// Ports
//   clk, rst_n   sampling clock (posedge), async active-low reset
//   en           monitor enable; low aborts pending attempts silently
//   clr          sync clear of counters and sticky flags
//   mode         00 rise, 01 fall, 10 any edge, 11 stable
//   a, b         antecedent / consequent per channel
//   pass_pulse   one-cycle pulse per passed attempt
//   fail_pulse   one-cycle pulse per failed attempt
//   busy         attempt pending (window open)
//   err_sticky   set on any fail
//   pass_cnt     saturating pass counters, ch i at [i*CNT_W +: CNT_W]
//   fail_cnt     saturating fail counters, same packing
//
// state  | meaning
// IDLE   | no attempt open; a=1 starts one
// PEND   | attempt open, waiting for the edge until wcnt reaches WINDOW
module edge_implication_monitor #(
   parameter int CHANNELS = 4,
   parameter int WINDOW   = 0,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      clr,
   input  logic [1:0]                mode,
   input  logic [CHANNELS-1:0]       a,
   input  logic [CHANNELS-1:0]       b,
   output logic [CHANNELS-1:0]       pass_pulse,
   output logic [CHANNELS-1:0]       fail_pulse,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       err_sticky,
   output logic [CHANNELS*CNT_W-1:0] pass_cnt,
   output logic [CHANNELS*CNT_W-1:0] fail_cnt
);

   localparam int WCNT_W = (WINDOW < 1) ? 1 : $clog2(WINDOW + 1);
   localparam logic [WCNT_W-1:0] WIN_L   = WCNT_W'(WINDOW);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PEND = 1'b1;

   logic [CHANNELS-1:0]        b_q;
   logic [CHANNELS-1:0]        state_q, state_d;
   logic [CHANNELS*WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [CHANNELS-1:0]        pass_q, pass_d;
   logic [CHANNELS-1:0]        fail_q, fail_d;
   logic [CHANNELS-1:0]        err_q, err_d;
   logic [CHANNELS*CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CHANNELS*CNT_W-1:0]  fcnt_q, fcnt_d;
   logic [CHANNELS-1:0]        edge_hit;

   // Edge qualifier against the previous sample; b_q tracks b even when
   // disabled so re-enabling does not see a stale edge.
   always_comb begin
      case (mode)
         2'b00:   edge_hit = b & ~b_q;
         2'b01:   edge_hit = ~b & b_q;
         2'b10:   edge_hit = b ^ b_q;
         default: edge_hit = ~(b ^ b_q);
      endcase
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pass_d  = '0;
      fail_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!en) begin
            state_d[i]                    = S_IDLE;
            wcnt_d[i*WCNT_W +: WCNT_W]    = '0;
         end else if (state_q[i] == S_IDLE) begin
            if (a[i]) begin
               if (edge_hit[i]) begin
                  pass_d[i] = 1'b1;
               end else if (WINDOW == 0) begin
                  fail_d[i] = 1'b1;
               end else begin
                  state_d[i]                 = S_PEND;
                  wcnt_d[i*WCNT_W +: WCNT_W] = WCNT_W'(1);
               end
            end
         end else begin
            // New antecedents are ignored while an attempt is open.
            if (edge_hit[i]) begin
               pass_d[i]                  = 1'b1;
               state_d[i]                 = S_IDLE;
               wcnt_d[i*WCNT_W +: WCNT_W] = '0;
            end else if (wcnt_q[i*WCNT_W +: WCNT_W] == WIN_L) begin
               fail_d[i]                  = 1'b1;
               state_d[i]                 = S_IDLE;
               wcnt_d[i*WCNT_W +: WCNT_W] = '0;
            end else begin
               wcnt_d[i*WCNT_W +: WCNT_W] = wcnt_q[i*WCNT_W +: WCNT_W] + WCNT_W'(1);
            end
         end
      end
   end

   // clr wins over a coinciding resolution: the event pulses but is not counted.
   always_comb begin
      pcnt_d = pcnt_q;
      fcnt_d = fcnt_q;
      err_d  = clr ? '0 : (err_q | fail_d);
      for (int i = 0; i < CHANNELS; i++) begin
         if (clr) begin
            pcnt_d[i*CNT_W +: CNT_W] = '0;
            fcnt_d[i*CNT_W +: CNT_W] = '0;
         end else begin
            if (pass_d[i] && (pcnt_q[i*CNT_W +: CNT_W] != CNT_MAX))
               pcnt_d[i*CNT_W +: CNT_W] = pcnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            if (fail_d[i] && (fcnt_q[i*CNT_W +: CNT_W] != CNT_MAX))
               fcnt_d[i*CNT_W +: CNT_W] = fcnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q     <= '0;
         state_q <= '0;
         wcnt_q  <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         err_q   <= '0;
         pcnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         b_q     <= b;
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         pcnt_q  <= pcnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign pass_pulse = pass_q;
   assign fail_pulse = fail_q;
   assign busy       = state_q;
   assign err_sticky = err_q;
   assign pass_cnt   = pcnt_q;
   assign fail_cnt   = fcnt_q;

endmodule
